// File: rtl/aes_display_pkg.sv
// Shared types and sizes for the AES result pager and its display-side helpers.
package aes_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RESULT,
        SHOW
    } pager_state_t;

    localparam int PAGE_W     = 16;
    localparam int NUM_PAGES  = 8;
    localparam int COUNT_W    = 32;
    localparam int RESULT_W   = PAGE_W * NUM_PAGES;
    localparam int PAGE_IDX_W = $clog2(NUM_PAGES);

    // Bit 0 of the result is the MSB, so page 0 is the leftmost 16 bits.
    function automatic logic [0:PAGE_W-1] page_slice(input logic [0:RESULT_W-1] result,
                                                     input logic [PAGE_IDX_W-1:0] page);
        return result[PAGE_W*page +: PAGE_W];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for a raw pushbutton; emits one
// pulse per accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            o_level      <= 1'b0;
            o_rise_pulse <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], i_btn};
            o_rise_pulse <= 1'b0;
            if (sync_q[1] != o_level) begin
                if (cnt_q == CNT_LAST) begin
                    o_level      <= sync_q[1];
                    o_rise_pulse <= sync_q[1];
                    cnt_q        <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/aes_result_pager.sv
// Captures an AES result, measures core latency, and pages the 128-bit block
// out to a four-digit display 16 bits at a time.
module aes_result_pager
    import aes_display_pkg::*;
#(
    parameter int DWELL_CYCLES    = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                i_start,
    input  logic [0:RESULT_W-1] i_result,
    input  logic                i_result_valid,
    input  logic                i_btn_next,
    input  logic                i_auto,
    output logic [0:PAGE_W-1]   o_data,
    output logic [0:COUNT_W-1]  o_count,
    output logic                o_refresh_display,
    output logic [2:0]          o_page,
    output logic                o_busy
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    pager_state_t        state_q;
    logic [0:RESULT_W-1] result_q;
    logic [COUNT_W-1:0]  lat_q;
    logic [DWELL_W-1:0]  dwell_q;

    logic               btn_level, btn_rise;
    logic               dwell_tick_d, advance_d;
    logic [2:0]         page_d;
    logic [COUNT_W-1:0] lat_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk          (clk),
        .clr          (clr),
        .i_btn        (i_btn_next),
        .o_level      (btn_level),
        .o_rise_pulse (btn_rise)
    );

    always_comb begin
        dwell_tick_d = i_auto && (dwell_q == DWELL_LAST);
        advance_d    = (state_q == SHOW) && ((btn_rise && btn_level) || dwell_tick_d);
        page_d       = o_page + 3'd1;
        lat_d        = (lat_q == '1) ? lat_q : lat_q + 1'b1;
    end

    // NOTE: the result block is pure datapath, only read after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == WAIT_RESULT && i_result_valid && !i_start) begin
            result_q <= i_result;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q           <= IDLE;
            lat_q             <= '0;
            dwell_q           <= '0;
            o_data            <= '0;
            o_count           <= '0;
            o_refresh_display <= 1'b0;
            o_page            <= '0;
            o_busy            <= 1'b0;
        end else begin
            o_refresh_display <= 1'b0;
            if (i_start) begin
                // A start always restarts measurement, even over a coincident result.
                state_q <= WAIT_RESULT;
                lat_q   <= COUNT_W'(1);
                dwell_q <= '0;
                o_busy  <= 1'b1;
            end else begin
                case (state_q)
                    WAIT_RESULT: begin
                        if (i_result_valid) begin
                            state_q           <= SHOW;
                            o_count           <= lat_q;
                            o_page            <= '0;
                            o_data            <= i_result[0:PAGE_W-1];
                            o_refresh_display <= 1'b1;
                            o_busy            <= 1'b0;
                            dwell_q           <= '0;
                        end else begin
                            lat_q <= lat_d;
                        end
                    end
                    SHOW: begin
                        if (advance_d) begin
                            o_page            <= page_d;
                            o_data            <= page_slice(result_q, page_d);
                            o_refresh_display <= 1'b1;
                            dwell_q           <= '0;
                        end else if (!i_auto) begin
                            dwell_q <= '0;
                        end else begin
                            dwell_q <= dwell_q + 1'b1;
                        end
                    end
                    default: begin
                        dwell_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_result_pager.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_aes_result_pager;

    localparam int DWELL = 8;
    localparam int DEB   = 4;
    localparam logic [0:127] R = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         clr, start, valid, btn, auto_en;
    logic [0:127] result;
    logic [0:15]  o_data;
    logic [0:31]  o_count;
    logic         o_ref;
    logic [2:0]   o_page;
    logic         o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ref_count = 0;
    int ref_cycles[$];

    logic [15:0] exp_words [8] = '{16'h0011, 16'h2233, 16'h4455, 16'h6677,
                                   16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};

    always #5 clk = ~clk;

    aes_result_pager #(
        .DWELL_CYCLES    (DWELL),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk               (clk),
        .clr               (clr),
        .i_start           (start),
        .i_result          (result),
        .i_result_valid    (valid),
        .i_btn_next        (btn),
        .i_auto            (auto_en),
        .o_data            (o_data),
        .o_count           (o_count),
        .o_refresh_display (o_ref),
        .o_page            (o_page),
        .o_busy            (o_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [0:127] m_result;
    longint       m_lat;
    logic [31:0]  m_count;
    int           m_page, m_dwell, m_run;
    logic [15:0]  m_data;
    bit           m_ref, m_busy, m_show;
    bit           m_s1, m_s2, m_acc, m_rise;

    task model_step();
        bit rise_now;
        rise_now = m_rise;
        if (clr) begin
            m_lat = 0; m_count = '0; m_page = 0; m_data = '0; m_ref = 0;
            m_busy = 0; m_show = 0; m_dwell = 0;
            m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0; m_rise = 0;
        end else begin
            m_ref = 0;
            if (start) begin
                m_busy = 1; m_show = 0; m_lat = 1; m_dwell = 0;
            end else if (m_busy) begin
                if (valid) begin
                    m_result = result;
                    m_count  = m_lat[31:0];
                    m_page   = 0;
                    m_data   = result[0:15];
                    m_ref    = 1;
                    m_busy   = 0;
                    m_show   = 1;
                    m_dwell  = 0;
                end else begin
                    m_lat = (m_lat + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_lat + 1;
                end
            end else if (m_show) begin
                if (rise_now || (auto_en && m_dwell == DWELL - 1)) begin
                    m_page  = (m_page + 1) % 8;
                    m_data  = m_result[16*m_page +: 16];
                    m_ref   = 1;
                    m_dwell = 0;
                end else begin
                    m_dwell = auto_en ? m_dwell + 1 : 0;
                end
            end
            // Accept a new level once the synchronised input has differed for DEB clocks.
            m_rise = 0;
            if (m_s2 != m_acc) begin
                m_run++;
                if (m_run == DEB) begin
                    m_acc  = m_s2;
                    m_run  = 0;
                    m_rise = m_acc;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        cyc++;
        #2;
        check("data",    64'(o_data),  64'(m_data));
        check("count",   64'(o_count), 64'(m_count));
        check("refresh", 64'(o_ref),   64'(m_ref));
        check("page",    64'(o_page),  64'(m_page));
        check("busy",    64'(o_busy),  64'(m_busy));
        if (o_ref === 1'b1) begin
            ref_count++;
            ref_cycles.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input int hi, input int lo);
        btn = 1'b1;
        repeat (hi) @(negedge clk);
        btn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        int base;
        logic [0:127] r2;
        clr = 1'b1; start = 1'b0; valid = 1'b0; btn = 1'b0; auto_en = 1'b0; result = '0;
        repeat (3) @(negedge clk);
        check("rst_data",  64'(o_data),  64'h0);
        check("rst_count", 64'(o_count), 64'h0);
        check("rst_ref",   64'(o_ref),   64'h0);
        check("rst_page",  64'(o_page),  64'h0);
        check("rst_busy",  64'(o_busy),  64'h0);
        clr = 1'b0;

        // Test 1: start at t=0, valid at t=10.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_busy_wait", 64'(o_busy), 64'h1);
        repeat (9) @(negedge clk);
        result = R; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; result = '0;
        check("t1_count", 64'(o_count), 64'd10);
        check("t1_data",  64'(o_data),  64'h0011);
        check("t1_page",  64'(o_page),  64'h0);
        check("t1_ref",   64'(o_ref),   64'h1);
        check("t1_busy",  64'(o_busy),  64'h0);

        // Test 2: eight full presses walk all pages and wrap.
        for (int p = 1; p <= 8; p++) begin
            base = ref_count;
            press(8, 8);
            check("t2_page",    64'(o_page), 64'(p % 8));
            check("t2_data",    64'(o_data), 64'(exp_words[p % 8]));
            check("t2_refresh", 64'(ref_count - base), 64'd1);
        end

        // Test 3: short glitches are ignored.
        base = ref_count;
        repeat (3) press(2, 6);
        check("t3_refresh", 64'(ref_count - base), 64'd0);
        check("t3_page",    64'(o_page), 64'h0);

        // Test 4: auto-advance every DWELL clocks.
        base = ref_count;
        ref_cycles.delete();
        auto_en = 1'b1;
        repeat (40) @(negedge clk);
        auto_en = 1'b0;
        check("t4_advances", 64'(ref_count - base), 64'd5);
        check("t4_page",     64'(o_page), 64'd5);
        for (int i = 1; i < ref_cycles.size(); i++)
            check("t4_gap", 64'(ref_cycles[i] - ref_cycles[i-1]), 64'(DWELL));
        // Button pulse lands on the same cycle as the first dwell tick.
        base = ref_count;
        auto_en = 1'b1;
        @(negedge clk);
        btn = 1'b1;
        repeat (8) @(negedge clk);
        auto_en = 1'b0; btn = 1'b0;
        repeat (8) @(negedge clk);
        check("t4_coincide", 64'(ref_count - base), 64'd1);
        check("t4_page2",    64'(o_page), 64'd6);

        // Test 5: restart from SHOW holds display; start beats valid.
        base = ref_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_busy", 64'(o_busy), 64'h1);
        check("t5_data", 64'(o_data), 64'hCCDD);
        press(8, 8);
        check("t5_page_hold", 64'(o_page), 64'd6);
        check("t5_no_ref",    64'(ref_count - base), 64'd0);
        start = 1'b1; valid = 1'b1;
        result = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
        check("t5_start_wins", 64'(o_busy),  64'h1);
        check("t5_count_hold", 64'(o_count), 64'd10);
        repeat (2) @(negedge clk);
        r2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        result = r2; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("t5_count", 64'(o_count), 64'd3);
        check("t5_data2", 64'(o_data),  64'(r2[0:15]));
        check("t5_page0", 64'(o_page),  64'h0);

        // Test 6: clear during WAIT_RESULT.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t6_data",  64'(o_data),  64'h0);
        check("t6_count", 64'(o_count), 64'h0);
        check("t6_page",  64'(o_page),  64'h0);
        check("t6_busy",  64'(o_busy),  64'h0);
        result = R; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("t6_ignore_data", 64'(o_data), 64'h0);
        check("t6_ignore_ref",  64'(o_ref),  64'h0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            start  = ($urandom_range(0, 39) == 0);
            valid  = ($urandom_range(0, 5) == 0);
            result = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 6) == 0) btn = ~btn;
            clr = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        start = 1'b0; valid = 1'b0; clr = 1'b0; btn = 1'b0; auto_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_result_pager.md
# aes_result_pager

Upstream feeder for the four-digit seven-segment display driver. Captures the 128-bit AES core result and measures the core's latency in clock cycles. Presents the result to the display one 16-bit page at a time, advanced by a debounced pushbutton or an auto-dwell timer. Drives the display's `i_data`, `i_count` and `i_refresh_display` inputs directly.

## Interface
Parameters:
- `DWELL_CYCLES`, 100_000_000: auto-advance period in clocks (1 s at 100 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000: clocks the synchronised button must hold a new level before it is accepted; must be ≥ 1.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `clr` in 1: reset. **One clock; reset is synchronous and active-high.**
- `i_start` in 1: one-cycle pulse; the AES core was launched this cycle.
- `i_result` in [0:127]: AES output block. Bit 0 is the MSB.
- `i_result_valid` in 1: one-cycle pulse; `i_result` is valid this cycle.
- `i_btn_next` in 1: raw asynchronous pushbutton, active-high.
- `i_auto` in 1: level; 1 enables auto-advance.
- `o_data` out [0:15]: current page, i.e. `result[16*page : 16*page+15]`.
- `o_count` out [0:31]: measured latency of the last completed operation.
- `o_refresh_display` out 1: one-cycle pulse, asserted in the same cycle `o_data` takes a new value.
- `o_page` out [2:0]: current page index, 0–7.
- `o_busy` out 1: 1 while waiting for a result.

## Operation
- States: IDLE, WAIT_RESULT, SHOW. Reset enters IDLE.
- **IDLE → WAIT_RESULT** on `i_start`. The cycle counter is loaded with 1.
- **SHOW → WAIT_RESULT** on `i_start`. The counter is loaded with 1.
- **WAIT_RESULT:**
  - Each cycle without `i_result_valid`: counter +1, saturating at 0xFFFF_FFFF.
  - On `i_result_valid`: latch `i_result`, set `o_count` to the counter, set page to 0, load `o_data` with `i_result[0:15]`, pulse `o_refresh_display`, go to SHOW.
  - Result: valid N cycles after the start cycle gives `o_count` = N.
- `i_start` and `i_result_valid` in the same cycle in WAIT_RESULT: start wins. The counter restarts and the result is ignored.
- `i_result_valid` in IDLE or SHOW: ignored.
- **SHOW, advance events:**
  - Event sources: a debounced rising edge of `i_btn_next`, or a dwell tick when `i_auto` = 1.
  - An event sets page to (page+1) mod 8; 7 wraps to 0.
  - On an event, reload `o_data` and pulse `o_refresh_display`.
  - Both sources in the same cycle: exactly one advance.
- **Dwell counter:**
  - Cleared on entry to SHOW, on every advance, and whenever `i_auto` = 0.
  - A tick occurs when the counter reaches `DWELL_CYCLES-1`.
- **WAIT_RESULT holds the display:** `o_data`, `o_page` and `o_count` keep their previous values, no refresh pulse is issued, and button edges are discarded. `o_busy` = 1 only in WAIT_RESULT.
- **Debounce:** 2-flop synchroniser, then a stability counter.
  - The accepted level changes after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive clocks.
  - One pulse per accepted 0→1 transition.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no pulse.

## Timing
- Reset values: `o_data`=0, `o_count`=0, `o_refresh_display`=0, `o_page`=0, `o_busy`=0. Internal: state IDLE, both counters 0, accepted button level 0.
- `clr` mid-operation: takes effect at the next edge. A pending result is lost and there is no refresh pulse.
- Latency from `i_result_valid` to `o_data`/`o_refresh_display`: 1 clock (registered).
- Latency from a button event to `o_data` update: one clock after the debounce pulse.
- Button rising edge held stable: pulse appears `DEBOUNCE_CYCLES`+2 clocks after the raw edge (±1 for asynchronous sampling).
- Auto mode with no button activity: refresh pulses exactly `DWELL_CYCLES` clocks apart.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `aes_display_pkg`:
  - state enum `pager_state_t` (IDLE, WAIT_RESULT, SHOW)
  - `PAGE_W`=16, `NUM_PAGES`=8, `COUNT_W`=32
- Sub-module `btn_debounce`:
  - parameter `DEBOUNCE_CYCLES`
  - ports `clk`, `clr`, `i_btn`, `o_level`, `o_rise_pulse`
  - Reusable for other board buttons.
- The pager itself holds the FSM, the 128-bit result register, the latency counter, the dwell counter, and the page mux.

## Test plan
Bench parameters: `DWELL_CYCLES`=8, `DEBOUNCE_CYCLES`=4. Result R = 0x00112233445566778899AABBCCDDEEFF.
1. `i_start` at t=0, valid with R at t=10 → at t=11 `o_count`=10, `o_data`=0x0011, `o_page`=0, one refresh pulse, `o_busy` 1→0.
2. Hold the button high for 8 clocks, seven times → pages step 1..7, `o_data`=0x2233 … 0xEEFF. An eighth press → page 0, 0x0011. Exactly one refresh pulse per press.
3. Button glitches of 2 clocks high → no advance, no refresh pulse.
4. `i_auto`=1 for 40 clocks in SHOW → 5 advances, 8 clocks apart. A button pulse coinciding with a dwell tick → a single advance.
5. Restart `i_start` in SHOW → `o_busy`=1, `o_data` holds, no refresh. A simultaneous start+valid in WAIT_RESULT restarts the count. A later valid at N=3 → `o_count`=3.
6. `clr` asserted in WAIT_RESULT → next edge gives all outputs 0, state IDLE. A valid afterwards → no change.
